// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared phase codes, state type and default dwell lengths
package phase_seq_pkg;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_1    = 2'b01;
    localparam logic [1:0] PH_2    = 2'b10;

    localparam int DEF_LEN1_C = 4;
    localparam int DEF_LEN2_C = 15;

    // State encoding doubles as the exported phase code.
    typedef enum logic [1:0] {
        ST_IDLE = PH_IDLE,
        ST_PH1  = PH_1,
        ST_PH2  = PH_2
    } state_t;

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - shared in-phase up-counter with terminal-count compare
module phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    // Count every cycle; clear on phase entry or while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;
    // len is never 0, so len-1 cannot underflow and the count never wraps.
    assign last  = (count_q == (len - CNT_W'(1)));

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - two-phase dwell sequencer with abort, repeat and status pulses
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int DEF_LEN1 = DEF_LEN1_C,
    parameter int DEF_LEN2 = DEF_LEN2_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic [CNT_W-1:0] len1,
    input  logic [CNT_W-1:0] len2,
    output logic [1:0]       z,
    output logic [CNT_W-1:0] counter,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [CNT_W-1:0] DEF1 = CNT_W'(DEF_LEN1);
    localparam logic [CNT_W-1:0] DEF2 = CNT_W'(DEF_LEN2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] l1_q, l1_d;
    logic [CNT_W-1:0] l2_q, l2_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic [CNT_W-1:0] len1_eff, len2_eff;
    logic [CNT_W-1:0] cnt_len;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_clr;

    assign len1_eff = (len1 == '0) ? DEF1 : len1;
    assign len2_eff = (len2 == '0) ? DEF2 : len2;

    // One counter serves both phases; compare against the active phase length.
    assign cnt_len = (state_q == ST_PH2) ? l2_q : l1_q;
    assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE);

    phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .len   (cnt_len),
        .count (cnt),
        .last  (cnt_last)
    );

    // State, latched lengths and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            l1_q      <= DEF1;
            l2_q      <= DEF2;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            l1_q      <= l1_d;
            l2_q      <= l2_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state: abort beats phase end, repeat and start; lengths latch on start and on repeat.
    always_comb begin
        state_d   = state_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (x && !abort) begin
                    state_d = ST_PH1;
                    l1_d    = len1_eff;
                    l2_d    = len2_eff;
                end
            end
            ST_PH1: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_last) begin
                    state_d = ST_PH2;
                end
            end
            ST_PH2: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_last) begin
                    done_d = 1'b1;
                    if (repeat_en) begin
                        state_d = ST_PH1;
                        l1_d    = len1_eff;
                        l2_d    = len2_eff;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign z       = state_q;
    assign counter = cnt;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer
module tb_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       x;
    logic       abort;
    logic       repeat_en;
    logic [3:0] len1;
    logic [3:0] len2;
    logic [1:0] z;
    logic [3:0] counter;
    logic       busy;
    logic       done;
    logic       aborted;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .abort     (abort),
        .repeat_en (repeat_en),
        .len1      (len1),
        .len2      (len2),
        .z         (z),
        .counter   (counter),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got z=%b cnt=%0d busy=%b done=%b ab=%b, want z=%b cnt=%0d busy=%b done=%b ab=%b",
                     nm, act[8:7], act[6:3], act[2], act[1], act[0],
                     exp_v[8:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, {z, counter, busy, done, aborted}, e.v);
        end
    end

    // Push the expected outputs after the next edge, then advance to the following negedge.
    task automatic cyc(input logic [1:0] ez, input int ec, input logic ed, input logic ea, input string nm);
        exp_t e;
        e.name = nm;
        e.v    = {ez, 4'(ec), (ez != 2'b00), ed, ea};
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ph(input logic [1:0] ez, input int from, input int to, input string nm);
        for (int i = from; i <= to; i++) cyc(ez, i, 1'b0, 1'b0, nm);
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; abort = 1'b0; repeat_en = 1'b0; len1 = 4'd0; len2 = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc(2'b00, 0, 0, 0, "reset_idle");
        cyc(2'b00, 0, 0, 0, "idle_hold");

        // Default lengths: 4 + 15 busy cycles then done.
        x = 1'b1; cyc(2'b01, 0, 0, 0, "def_start");
        x = 1'b0; ph(2'b01, 1, 3, "def_ph1");
        ph(2'b10, 0, 14, "def_ph2");
        cyc(2'b00, 0, 1, 0, "def_done");
        cyc(2'b00, 0, 0, 0, "def_after");

        // Programmed 2/3; mid-sequence change to 7/7 is used only by the next start.
        len1 = 4'd2; len2 = 4'd3;
        x = 1'b1; cyc(2'b01, 0, 0, 0, "prog_start");
        x = 1'b0; len1 = 4'd7; len2 = 4'd7;
        cyc(2'b01, 1, 0, 0, "prog_ph1");
        ph(2'b10, 0, 2, "prog_ph2");
        cyc(2'b00, 0, 1, 0, "prog_done");
        x = 1'b1; cyc(2'b01, 0, 0, 0, "prog7_start");
        x = 1'b0; ph(2'b01, 1, 6, "prog7_ph1");
        ph(2'b10, 0, 6, "prog7_ph2");
        cyc(2'b00, 0, 1, 0, "prog7_done");
        len1 = 4'd0; len2 = 4'd0;

        // Abort at PH2 counter 5 with x held high; restart only from idle.
        x = 1'b1; cyc(2'b01, 0, 0, 0, "ab_start");
        ph(2'b01, 1, 3, "ab_ph1");
        ph(2'b10, 0, 5, "ab_ph2");
        abort = 1'b1; cyc(2'b00, 0, 0, 1, "ab_pulse");
        abort = 1'b0; cyc(2'b01, 0, 0, 0, "ab_restart");
        x = 1'b0; cyc(2'b01, 1, 0, 0, "ab_ph1b");
        abort = 1'b1; cyc(2'b00, 0, 0, 1, "ab_ph1_pulse");
        x = 1'b1; cyc(2'b00, 0, 0, 0, "ab_idle_noop");
        abort = 1'b0; x = 1'b0;
        cyc(2'b00, 0, 0, 0, "ab_quiet");

        // Auto-repeat 1/2, re-latch 2/1 at a repeat, then stop.
        repeat_en = 1'b1; len1 = 4'd1; len2 = 4'd2;
        x = 1'b1; cyc(2'b01, 0, 0, 0, "rep_start");
        x = 1'b0; cyc(2'b10, 0, 0, 0, "rep_ph2a");
        cyc(2'b10, 1, 0, 0, "rep_ph2b");
        cyc(2'b01, 0, 1, 0, "rep_wrap1");
        cyc(2'b10, 0, 0, 0, "rep_ph2c");
        len1 = 4'd2; len2 = 4'd1;
        cyc(2'b10, 1, 0, 0, "rep_ph2d");
        cyc(2'b01, 0, 1, 0, "rep_wrap2");
        cyc(2'b01, 1, 0, 0, "rep_ph1_relatch");
        cyc(2'b10, 0, 0, 0, "rep_ph2_len1");
        repeat_en = 1'b0;
        cyc(2'b00, 0, 1, 0, "rep_stop");
        cyc(2'b00, 0, 0, 0, "rep_idle");

        // Boundary: full 15-cycle PH2, then abort on the PH2 last cycle.
        len1 = 4'd1; len2 = 4'd15;
        x = 1'b1; cyc(2'b01, 0, 0, 0, "bnd_start");
        x = 1'b0; ph(2'b10, 0, 14, "bnd_ph2");
        cyc(2'b00, 0, 1, 0, "bnd_done");
        x = 1'b1; cyc(2'b01, 0, 0, 0, "bnd2_start");
        x = 1'b0; ph(2'b10, 0, 14, "bnd2_ph2");
        abort = 1'b1; cyc(2'b00, 0, 0, 1, "bnd_abort_last");
        abort = 1'b0; cyc(2'b00, 0, 0, 0, "bnd_no_done");
        len1 = 4'd0; len2 = 4'd0;

        // Asynchronous reset mid-PH1, then a fresh default sequence.
        x = 1'b1; cyc(2'b01, 0, 0, 0, "rst_start");
        x = 1'b0; cyc(2'b01, 1, 0, 0, "rst_ph1");
        #3 rst = 1'b1;
        #1 check("async_rst", {z, counter, busy, done, aborted}, 9'b0);
        @(negedge clk);
        rst = 1'b0;
        x = 1'b1; cyc(2'b01, 0, 0, 0, "post_rst_start");
        x = 1'b0; ph(2'b01, 1, 3, "post_rst_ph1");
        ph(2'b10, 0, 14, "post_rst_ph2");
        cyc(2'b00, 0, 1, 0, "post_rst_done");

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
